// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : Registered two-entry skid buffer behind the ALU result merge.
//            Captures result/carry/overflow/opcode, derives the zero flag
//            at capture, and hands results to the consumer under a
//            valid/ready handshake. Keeps a wrapping retire counter.
// Revision : 1.0  initial release
// ============================================================================
module alu_result_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_carryout,
  input  logic        in_overflow,
  input  logic [2:0]  in_opcode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_carryout,
  output logic        out_overflow,
  output logic [2:0]  out_opcode,
  output logic [15:0] retire_count
);

  // Occupancy states; the encoding doubles as the entry count.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        wptr_q;
  logic        rptr_q;
  logic [15:0] retire_q;

  logic [31:0] result_q   [2];
  logic        zero_q     [2];
  logic        carry_q    [2];
  logic        overflow_q [2];
  logic [2:0]  opcode_q   [2];

  logic        push;
  logic        pop;
  logic        flags_kept;

  // Handshakes qualify against the registered ready/valid only.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Carry/overflow are meaningful only for the adder opcodes (ADD=0, SUB=1).
  assign flags_kept = (in_opcode[2:1] == 2'b00);

  // State register: occupancy tracks the number of buffered entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: +1 on push only, -1 on pop only, hold otherwise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push)          state_d = S_ONE;
      S_ONE: begin
        if (push && !pop)         state_d = S_TWO;
        else if (pop && !push)    state_d = S_EMPTY;
      end
      S_TWO:   if (pop)           state_d = S_ONE;
      default:                    state_d = S_EMPTY;
    endcase
  end

  // Output logic: handshake flags come straight from the registered state.
  always_comb begin
    in_ready  = (state_q != S_TWO);
    out_valid = (state_q != S_EMPTY);
  end

  // Pointer and retire counter update; the counter wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      retire_q <= 16'd0;
    end else begin
      if (push) wptr_q <= ~wptr_q;
      if (pop) begin
        rptr_q   <= ~rptr_q;
        retire_q <= retire_q + 16'd1;
      end
    end
  end

  // Entry storage; cleared on reset so head outputs are never X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        result_q[i]   <= 32'd0;
        zero_q[i]     <= 1'b0;
        carry_q[i]    <= 1'b0;
        overflow_q[i] <= 1'b0;
        opcode_q[i]   <= 3'd0;
      end
    end else if (push) begin
      result_q[wptr_q]   <= in_result;
      zero_q[wptr_q]     <= (in_result == 32'd0);
      carry_q[wptr_q]    <= in_carryout && flags_kept;
      overflow_q[wptr_q] <= in_overflow && flags_kept;
      opcode_q[wptr_q]   <= in_opcode;
    end
  end

  // Head entry is always presented, valid or not.
  always_comb begin
    out_result   = result_q[rptr_q];
    out_zero     = zero_q[rptr_q];
    out_carryout = carry_q[rptr_q];
    out_overflow = overflow_q[rptr_q];
    out_opcode   = opcode_q[rptr_q];
    retire_count = retire_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_stage
// Purpose  : Directed self-checking bench for alu_result_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carryout;
  logic        in_overflow;
  logic [2:0]  in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_carryout;
  logic        out_overflow;
  logic [2:0]  out_opcode;
  logic [15:0] retire_count;

  int tests_run;
  int tests_failed;

  alu_result_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carryout  (in_carryout),
    .in_overflow  (in_overflow),
    .in_opcode    (in_opcode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_carryout (out_carryout),
    .out_overflow (out_overflow),
    .out_opcode   (out_opcode),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic c,
                       input logic o, input logic [2:0] op);
    in_valid    = v;
    in_result   = r;
    in_carryout = c;
    in_overflow = o;
    in_opcode   = op;
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 3'd0);
    out_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    tests_run++;
    if (out_result !== 32'd0 || out_zero !== 1'b0 || out_carryout !== 1'b0 ||
        out_overflow !== 1'b0 || out_opcode !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_fields: result=%h zero=%b c=%b o=%b op=%0d, required all 0",
               out_result, out_zero, out_carryout, out_overflow, out_opcode);
    end
    tests_run++;
    if (retire_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_retire: got %0d, required 0", retire_count);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_add();
    drive(1'b1, 32'h0000_0000, 1'b1, 1'b0, 3'd0);
    tick();
    drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'd7);
    tests_run++;
    if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_carryout !== 1'b1 ||
        out_overflow !== 1'b0 || out_opcode !== 3'd0 || out_result !== 32'd0) begin
      tests_failed++;
      $display("FAIL add_capture: v=%b z=%b c=%b o=%b op=%0d r=%h, required 1 1 1 0 0 00000000",
               out_valid, out_zero, out_carryout, out_overflow, out_opcode, out_result);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (retire_count !== 16'd1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_pop: retire=%0d out_valid=%b, required 1 0", retire_count, out_valid);
    end
  endtask

  task automatic test_flag_mask();
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'd2);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);
    tests_run++;
    if (out_carryout !== 1'b0 || out_overflow !== 1'b0 || out_zero !== 1'b0 ||
        out_opcode !== 3'd2 || out_result !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL xor_mask: c=%b o=%b z=%b op=%0d r=%h, required 0 0 0 2 ffffffff",
               out_carryout, out_overflow, out_zero, out_opcode, out_result);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (retire_count !== 16'd2 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL xor_pop: retire=%0d out_valid=%b, required 2 0", retire_count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 1'b1, 1'b0, 3'd4);
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || out_result !== 32'h11 || out_carryout !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_first: in_ready=%b r=%h c=%b, required 1 00000011 0", in_ready, out_result, out_carryout);
    end
    drive(1'b1, 32'h22, 1'b0, 1'b1, 3'd1);
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || out_result !== 32'h11) begin
      tests_failed++;
      $display("FAIL bp_full: in_ready=%b r=%h, required 0 00000011", in_ready, out_result);
    end
    drive(1'b1, 32'h33, 1'b0, 1'b0, 3'd7);
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h11) begin
      tests_failed++;
      $display("FAIL bp_hold: in_ready=%b v=%b r=%h, required 0 1 00000011", in_ready, out_valid, out_result);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_result !== 32'h22 || out_overflow !== 1'b1 || out_opcode !== 3'd1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_second: r=%h o=%b op=%0d in_ready=%b, required 00000022 1 1 1",
               out_result, out_overflow, out_opcode, in_ready);
    end
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);
    tests_run++;
    if (out_valid !== 1'b1 || out_result !== 32'h33 || out_opcode !== 3'd7) begin
      tests_failed++;
      $display("FAIL bp_third: v=%b r=%h op=%0d, required 1 00000033 7", out_valid, out_result, out_opcode);
    end
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || retire_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL bp_drain: v=%b retire=%0d, required 0 5", out_valid, retire_count);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'hAA, 1'b0, 1'b0, 3'd6);
    tick();
    drive(1'b1, 32'hBB, 1'b0, 1'b0, 3'd5);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_full: in_ready=%b v=%b, required 0 1", in_ready, out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || retire_count !== 16'd0 || out_result !== 32'd0) begin
      tests_failed++;
      $display("FAIL midrst_async: v=%b in_ready=%b retire=%0d r=%h, required 0 1 0 00000000",
               out_valid, in_ready, retire_count, out_result);
    end
    #1;
    reset = 1'b0;
    tick();
    drive(1'b1, 32'hCC, 1'b1, 1'b1, 3'd1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);
    tests_run++;
    if (out_valid !== 1'b1 || out_result !== 32'hCC || out_carryout !== 1'b1 || out_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_push: v=%b r=%h c=%b o=%b, required 1 000000cc 1 1",
               out_valid, out_result, out_carryout, out_overflow);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || retire_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL midrst_pop: v=%b retire=%0d, required 0 1", out_valid, retire_count);
    end
  endtask

  task automatic test_stream();
    logic [31:0] val;
    logic [2:0]  op;
    logic        exp_flag;
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      val = 32'(i) * 32'd3 + 32'd7;
      op  = 3'(i % 8);
      drive(1'b1, val, 1'b1, 1'b1, op);
      tick();
      exp_flag = (op == 3'd0) || (op == 3'd1);
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== val || out_opcode !== op ||
          out_carryout !== exp_flag || out_overflow !== exp_flag) begin
        tests_failed++;
        $display("FAIL stream[%0d]: v=%b rdy=%b r=%h op=%0d c=%b o=%b, required 1 1 %h %0d %b %b",
                 i, out_valid, in_ready, out_result, out_opcode, out_carryout, out_overflow,
                 val, op, exp_flag, exp_flag);
      end
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || retire_count !== 16'd100) begin
      tests_failed++;
      $display("FAIL stream_end: v=%b retire=%0d, required 0 100", out_valid, retire_count);
    end
  endtask

  // Continues from 100 retired results to 65536 total pops.
  task automatic test_wrap();
    out_ready = 1'b1;
    drive(1'b1, 32'h5, 1'b0, 1'b0, 3'd7);
    for (int i = 0; i < 65436; i++) tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);
    tests_run++;
    if (retire_count !== 16'hFFFF || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_pre: retire=%h v=%b, required ffff 1", retire_count, out_valid);
    end
    tick();
    tests_run++;
    if (retire_count !== 16'h0000 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_post: retire=%h v=%b, required 0000 0", retire_count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    out_ready    = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);
    test_reset();
    test_single_add();
    test_flag_mask();
    test_backpressure();
    test_mid_reset();
    test_stream();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the 32-bit bitwise gate arrays and the deciding OR that merges the per-operation ALU results. It captures the merged 32-bit result with its carry/overflow bits and opcode, derives the zero flag, and holds up to two results in a skid buffer. Results are presented to the writeback/consumer side under a valid/ready handshake, so the ALU can be issued back-to-back while the consumer stalls. A wrapping retire counter supports bench and performance visibility.

## Interface
- No parameters; data width is fixed at 32, depth fixed at 2.
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  upstream result valid this cycle
- in_ready  output  1  stage can accept; equals (count != 2)
- in_result  input  32  merged ALU result
- in_carryout  input  1  adder carry-out
- in_overflow  input  1  adder signed overflow
- in_opcode  input  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
- out_valid  output  1  head entry valid; equals (count != 0)
- out_ready  input  1  consumer accepts head
- out_result  output  32  head result
- out_zero  output  1  head result == 0
- out_carryout  output  1  head carry (0 unless opcode ADD/SUB)
- out_overflow  output  1  head overflow (0 unless opcode ADD/SUB)
- out_opcode  output  3  head opcode
- retire_count  output  16  number of pops, wraps

## Operation
- Storage: two entries {result, zero, carry, overflow, opcode}, write pointer, read pointer (1 bit each), count 0..2.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- On push: entry[wptr] <= captured fields; wptr toggles. zero computed from in_result at capture (all 32 bits == 0). carry/overflow stored masked: kept only for opcode 0/1, forced 0 otherwise.
- On pop: rptr toggles; retire_count += 1 (0xFFFF -> 0x0000).
- count: +1 push only, -1 pop only, unchanged for both or neither.
- States by count: EMPTY(0) -> ONE(1) on push; ONE -> TWO on push without pop; ONE -> EMPTY on pop without push; ONE stays on push+pop; TWO -> ONE on pop (no push possible, in_ready=0); TWO stays otherwise.
- Outputs are always driven from entry[rptr]; when out_valid=0 their values are don't-care but must be stable (no X after reset: entries reset to 0).
- Ordering strictly FIFO; no entry is dropped or duplicated.

## Timing
- Reset (async, immediate): count=0, wptr=rptr=0, entries=0, retire_count=0; hence out_valid=0, out_result=0, out_zero=0 (storage, not recomputed), out_carryout=0, out_overflow=0, out_opcode=0, in_ready=1. Pushes/pops presented while reset is high are ignored.
- Reset asserted mid-operation discards buffered entries; first push after release lands in entry 0.
- Latency: push at edge N into EMPTY -> out_valid=1 and fields visible after edge N (cycle N+1). No combinational in->out path.
- in_ready and out_valid depend only on count (registered); no combinational ready-through.
- Full throughput: with out_ready held 1, one result per cycle sustained in ONE state.
- Consumer stall: accepts exactly two results, then in_ready=0 until a pop; in_ready rises the cycle after that pop.
- Upstream must hold in_* stable while in_valid=1 and in_ready=0.

## Test plan
- Reset: assert reset mid-stream with count=2 -> immediately out_valid=0, in_ready=1, retire_count=0, out_result=0.
- Single ADD: push result 0x00000000, carry=1, overflow=0, opcode 0 into empty -> next cycle out_valid=1, out_zero=1, out_carryout=1; pop -> retire_count=1, out_valid=0.
- Flag masking: push XOR result 0xFFFFFFFF with in_carryout=1, in_overflow=1 -> out_carryout=0, out_overflow=0, out_zero=0, out_opcode=2.
- Backpressure: out_ready=0, push 0x11, 0x22, 0x33 on consecutive cycles -> 0x11, 0x22 accepted, in_ready=0 holds 0x33; raise out_ready -> outputs 0x11, 0x22, 0x33 in order, none lost.
- Simultaneous push+pop at count 1: stream 100 results with out_ready=1 -> count stays 1, one result per cycle, FIFO order, retire_count=100.
- Counter wrap: 65536 pops -> retire_count returns to 0x0000.
